// File: rtl/ant_launcher_pkg.sv
// ant_launcher_pkg: mesh geometry, packet layout and ant helpers shared by the launcher slice
package ant_launcher_pkg;
  localparam int X_NODES = 4;
  localparam int Y_NODES = 4;
  localparam int NODES = X_NODES * Y_NODES;
  localparam int X_W = $clog2(X_NODES);
  localparam int Y_W = $clog2(Y_NODES);
  localparam int NODE_W = $clog2(NODES);
  localparam int MEM_DEPTH = 8;
  localparam int MEM_W = $clog2(MEM_DEPTH + 1);
  localparam int PAYLOAD_W = 8;
  localparam int ANT_TS_W = 16;
  localparam int ANT_CNT_W = 16;
  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;
  typedef logic [NODE_W-1:0] node_t;
  typedef logic [ANT_TS_W-1:0] ts_t;
  typedef struct packed {
    logic ant;
    logic backward;
    x_t x_source;
    y_t y_source;
    x_t x_dest;
    y_t y_dest;
    logic [MEM_W-1:0] num_memories;
    logic [MEM_W-1:0] b_num_memories;
    logic [MEM_DEPTH-1:0][X_W-1:0] x_memory;
    logic [MEM_DEPTH-1:0][Y_W-1:0] y_memory;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PICK, S_SEND} state_t;
  function automatic node_t node_inc(input node_t n);
    return (n == node_t'(NODES - 1)) ? '0 : n + node_t'(1);
  endfunction
  function automatic node_t next_dest(input node_t n, input node_t self);
    node_t m;
    m = node_inc(n);
    return (m == self) ? node_inc(m) : m;
  endfunction
  function automatic x_t node_x(input node_t n);
    return x_t'(int'(n) % X_NODES);
  endfunction
  function automatic y_t node_y(input node_t n);
    return y_t'(int'(n) / X_NODES);
  endfunction
  function automatic packet_t build_ant(input x_t xs, input y_t ys, input node_t d);
    packet_t p;
    p = '0;
    p.ant = 1'b1;
    p.x_source = xs;
    p.y_source = ys;
    p.x_dest = node_x(d);
    p.y_dest = node_y(d);
    return p;
  endfunction
endpackage

// File: rtl/ant_outstanding_table.sv
// ant_outstanding_table: CAM of in-flight ants keyed by destination, with age-based expiry
module ant_outstanding_table
  import ant_launcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 512,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  ts_t           now,
  input  logic          alloc,
  input  x_t            alloc_x,
  input  y_t            alloc_y,
  input  logic          lookup,
  input  x_t            lookup_x,
  input  y_t            lookup_y,
  input  x_t            probe_x,
  input  y_t            probe_y,
  output logic          full,
  output logic          hit,
  output ts_t           hit_ts,
  output logic          probe_hit,
  output logic [CW-1:0] expired
);
  logic [DEPTH-1:0] valid, match, probe_m, exp_m, sel;
  x_t xs [DEPTH];
  y_t ys [DEPTH];
  ts_t ts [DEPTH];
  assign sel = ~valid & (valid + DEPTH'(1));
  assign full = &valid;
  assign hit = lookup && |match;
  assign probe_hit = |probe_m;
  // per-entry match and expiry; a return in the expiry cycle takes precedence over loss
  always_comb begin
    match = '0;
    probe_m = '0;
    exp_m = '0;
    hit_ts = '0;
    expired = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && xs[i] == lookup_x && ys[i] == lookup_y;
      probe_m[i] = valid[i] && xs[i] == probe_x && ys[i] == probe_y;
      exp_m[i] = valid[i] && ts_t'(now - ts[i]) >= ts_t'(TIMEOUT) && !(lookup && match[i]);
      hit_ts = hit_ts | (match[i] ? ts[i] : '0);
      expired = expired + CW'(exp_m[i]);
    end
  end
  // entries freed this cycle only become allocatable next cycle
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) valid[i] <= 1'b0;
      else if ((lookup && match[i]) || exp_m[i]) valid[i] <= 1'b0;
      else if (alloc && sel[i]) valid[i] <= 1'b1;
      if (alloc && sel[i]) begin
        xs[i] <= alloc_x;
        ys[i] <= alloc_y;
        ts[i] <= now;
      end
    end
endmodule

// File: rtl/ant_launcher.sv
// ant_launcher: periodic forward-ant injection and backward-ant collection at a node's local port
module ant_launcher
  import ant_launcher_pkg::*;
#(
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0,
  parameter int ANT_PERIOD = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  output packet_t              o_data,
  output logic                 o_data_val,
  input  logic                 i_data_ack,
  input  packet_t              i_data,
  input  logic                 i_data_val,
  output logic [ANT_CNT_W-1:0] o_ant_sent,
  output logic [ANT_CNT_W-1:0] o_ant_returned,
  output logic [ANT_CNT_W-1:0] o_ant_lost,
  output logic [ANT_CNT_W-1:0] o_ant_stray,
  output logic [ANT_TS_W-1:0]  o_rtt,
  output logic                 o_rtt_val
);
  localparam node_t SELF = node_t'(Y_LOC * X_NODES + X_LOC);
  localparam int PW = $clog2(ANT_PERIOD);
  localparam int EW = $clog2(MAX_OUTSTANDING + 1);
  state_t state, state_n;
  logic [PW-1:0] cnt;
  node_t ptr;
  ts_t now, hit_ts;
  logic full, hit, probe_hit, qual, go_send, skip, acked, unused_pkt;
  logic [EW-1:0] expired;
  assign qual = i_data_val && i_data.ant && i_data.backward &&
                i_data.x_dest == x_t'(X_LOC) && i_data.y_dest == y_t'(Y_LOC);
  assign unused_pkt = ^i_data;
  assign go_send = state == S_PICK && !full && !probe_hit;
  assign skip = state == S_PICK && !full && probe_hit;
  assign acked = state == S_SEND && i_data_ack;
  ant_outstanding_table #(.DEPTH(MAX_OUTSTANDING), .TIMEOUT(TIMEOUT)) u_table (
    .clk(clk),
    .reset(reset),
    .now(now),
    .alloc(acked),
    .alloc_x(node_x(ptr)),
    .alloc_y(node_y(ptr)),
    .lookup(qual),
    .lookup_x(i_data.x_source),
    .lookup_y(i_data.y_source),
    .probe_x(node_x(ptr)),
    .probe_y(node_y(ptr)),
    .full(full),
    .hit(hit),
    .hit_ts(hit_ts),
    .probe_hit(probe_hit),
    .expired(expired)
  );
  // launch sequencing: wait a period, pick a destination, hold the ant until acked
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = i_en ? S_WAIT : S_IDLE;
      S_WAIT: state_n = !i_en ? S_IDLE : (cnt == PW'(ANT_PERIOD - 1)) ? S_PICK : S_WAIT;
      S_PICK: state_n = go_send ? S_SEND : S_WAIT;
      S_SEND: state_n = i_data_ack ? S_WAIT : S_SEND;
      default: state_n = S_IDLE;
    endcase
  end
  // state, period counter, destination pointer (own index skipped while waiting) and timestamp
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      ptr <= '0;
      now <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == S_WAIT && state_n == S_WAIT) ? cnt + PW'(1) : '0;
      ptr <= (acked || skip || (state == S_WAIT && ptr == SELF)) ? next_dest(ptr, SELF) : ptr;
      now <= now + ts_t'(1);
    end
  // registered ant output, held stable until the router accepts it
  always_ff @(posedge clk)
    if (reset) begin
      o_data <= '0;
      o_data_val <= 1'b0;
    end else begin
      if (go_send) o_data <= build_ant(x_t'(X_LOC), y_t'(Y_LOC), ptr);
      o_data_val <= go_send ? 1'b1 : acked ? 1'b0 : o_data_val;
    end
  // statistics and round-trip reporting
  always_ff @(posedge clk)
    if (reset) begin
      o_ant_sent <= '0;
      o_ant_returned <= '0;
      o_ant_lost <= '0;
      o_ant_stray <= '0;
      o_rtt <= '0;
      o_rtt_val <= 1'b0;
    end else begin
      o_ant_sent <= o_ant_sent + ANT_CNT_W'(acked);
      o_ant_returned <= o_ant_returned + ANT_CNT_W'(hit);
      o_ant_stray <= o_ant_stray + ANT_CNT_W'(qual && !hit);
      o_ant_lost <= o_ant_lost + ANT_CNT_W'(expired);
      o_rtt <= hit ? now - hit_ts : o_rtt;
      o_rtt_val <= hit;
    end
endmodule

// File: doc/ant_launcher.md
# ant_launcher

Injection and collection endpoint for ACO ant packets at a node's PE-side local port. It periodically creates forward ants addressed to every other node in raster order and hands them to the local router input under a valid/ack handshake. It absorbs the backward ants that return to this node, matches each to its outstanding launch, and reports round-trip latency, lost-ant and stray-ant statistics. One instance sits per node beside the router's local (port 0) input and output.

## Interface
- X_LOC, none, X coordinate of this node
- Y_LOC, none, Y coordinate of this node
- ANT_PERIOD, 64, cycles between launch attempts (≥2)
- MAX_OUTSTANDING, 4, outstanding-ant table entries (≥1)
- TIMEOUT, 512, age in cycles after which an outstanding ant is declared lost (< 2^ANT_TS_W)
- clk, input, 1, clock; single clock domain
- reset, input, 1, synchronous, active-high reset
- i_en, input, 1, launch enable; collection runs regardless
- o_data, output, packet_t, forward ant to router local input
- o_data_val, output, 1, o_data valid
- i_data_ack, input, 1, router accepted o_data this cycle
- i_data, input, packet_t, packet ejected from router local output
- i_data_val, input, 1, i_data valid (always accepted, no back-pressure)
- o_ant_sent, output, 16, launched-ant count (wraps)
- o_ant_returned, output, 16, matched backward-ant count (wraps)
- o_ant_lost, output, 16, timed-out count (wraps)
- o_ant_stray, output, 16, unmatched backward-ant count (wraps)
- o_rtt, output, ANT_TS_W, last measured round trip
- o_rtt_val, output, 1, one-cycle pulse when o_rtt updates

## Operation
- Free-running timestamp counter `now`, ANT_TS_W bits, wraps modulo 2^ANT_TS_W.
- Destination pointer walks node index 0..NODES-1 (index = y*X_NODES + x), wraps, skips own index.
- FSM:
  - S_IDLE: leave when i_en=1 → S_WAIT, period counter cleared.
  - S_WAIT: count to ANT_PERIOD-1 → S_PICK. i_en=0 → S_IDLE.
  - S_PICK: 1 cycle. If table full → S_WAIT (attempt dropped; pointer unchanged). If current destination already outstanding, advance pointer and → S_WAIT. Otherwise build the ant → S_SEND.
  - S_SEND: o_data_val=1. On i_data_ack: allocate lowest free entry {dest, ts=now}, increment o_ant_sent, advance pointer → S_WAIT. i_en deasserting does not abort S_SEND.
- Built ant: ant=1, backward=0, x/y_source=X_LOC/Y_LOC, x/y_dest=pointer coords, num_memories=0, b_num_memories=0, all memory arrays and other fields zero.
- Collection, every cycle with i_data_val=1: qualified only when ant=1, backward=1, x_dest=X_LOC, y_dest=Y_LOC; all other packets are ignored. Match key is (x_source, y_source), which is the original destination after turnaround. On hit: free entry, o_rtt=(now-ts) mod 2^ANT_TS_W, pulse o_rtt_val, increment o_ant_returned. On miss: increment o_ant_stray.
- Timeout: each valid entry with (now-ts) ≥ TIMEOUT is freed and increments o_ant_lost. Multiple entries expiring in the same cycle add their total count.
- Same-cycle return and timeout on one entry: return wins, not counted lost.
- Same-cycle allocate (ack) and free: the freed slot is reusable from the next cycle.

## Timing
- Reset: all outputs 0, o_data=’0, FSM S_IDLE, pointer=0, table empty, now=0.
- From i_en rising, first o_data_val rises ANT_PERIOD+1 cycles later (own index skipped before S_PICK).
- o_data and o_data_val are registered and held stable until the acked cycle; val drops on the next cycle.
- Collection updates (counters, o_rtt, o_rtt_val) are registered, visible 1 cycle after i_data_val.
- Reset asserted mid-S_SEND drops the ant without counting it.

## Structure
- Shared package: packet_t, NODES, X_NODES, Y_NODES (existing); new ANT_TS_W=16 and ANT_CNT_W=16.
- Sub-module ant_outstanding_table: CAM of MAX_OUTSTANDING {valid, x, y, ts}, with allocate, lookup/free, expiry-count and full/hit outputs. The FSM and counters stay in ant_launcher.

## Test plan
- 4x4 mesh, node (1,1), ANT_PERIOD=8, ack held 1: ants to (0,0),(1,0),(2,0),(3,0),(0,1),(2,1) in order, (1,1) never; o_ant_sent=6.
- i_data_ack held 0 for 20 cycles in S_SEND: o_data_val stays 1 and o_data is unchanged; o_ant_sent increments only after ack.
- Backward ant with source (2,0) and dest (1,1) injected 37 cycles after its launch ack: o_rtt=37, o_rtt_val pulses once, o_ant_returned+1.
- MAX_OUTSTANDING=4 with no returns: 5th attempt dropped; TIMEOUT=512 → o_ant_lost=4 at 512 cycles after each entry's ts; launches resume.
- Backward ant for a never-launched source (3,3), and a normal packet: o_ant_stray+1 for the ant only; the normal packet has no effect.
- Return arriving in the exact expiry cycle → returned+1, lost unchanged. `now` wrap (ts=0xFFF0, return at 0x0010) → o_rtt=0x20. reset mid-S_SEND → all outputs 0 next cycle.
